// File: rtl/simd_issue_sequencer.sv
// Issue sequencer for the 4-lane SIMD datapath: queues R-type instructions in a small FIFO
// and walks each one through READ -> EXEC -> WRITE, driving the shared lane strobes.
module simd_issue_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          instr_valid,
    input  logic [16:0]                   instr_in,
    output logic                          instr_ready,
    output logic                          rs1_rd_en,
    output logic                          rs2_rd_en,
    output logic                          add_en,
    output logic                          sub_en,
    output logic                          bitrev_en,
    output logic                          mul_en,
    output logic                          rd_wr_en,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic [4:0]                    rd,
    output logic                          busy,
    output logic                          instr_done,
    output logic [CNT_W-1:0]              retire_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int EC_W  = $clog2(MUL_LAT + 1);

    localparam logic [1:0] OP_ADD    = 2'd0;
    localparam logic [1:0] OP_SUB    = 2'd1;
    localparam logic [1:0] OP_BITREV = 2'd2;
    localparam logic [1:0] OP_MUL    = 2'd3;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t             state_q, state_d;
    logic [16:0]        instr_q, instr_d;
    logic [EC_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]   retire_q, retire_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [16:0]        mem_q [FIFO_DEPTH];
    logic [16:0]        mem_d [FIFO_DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic [1:0] op;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = instr_valid && !full;
    // The head is consumed only where the FSM can accept a new instruction.
    assign pop   = enable && !empty && ((state_q == IDLE) || (state_q == WRITE));
    assign op    = instr_q[16:15];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = instr_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;
        retire_d = retire_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        instr_d = mem_q[rd_ptr_q];
                        state_d = READ;
                    end
                end
                READ: begin
                    state_d = EXEC;
                    cnt_d   = EC_W'(1);
                end
                EXEC: begin
                    if ((op != OP_MUL) || (cnt_q == EC_W'(MUL_LAT))) begin
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + EC_W'(1);
                    end
                end
                WRITE: begin
                    retire_d = retire_q + CNT_W'(1);
                    // Back-to-back issue: go straight to READ when work is waiting.
                    if (pop) begin
                        instr_d = mem_q[rd_ptr_q];
                        state_d = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            cnt_q    <= '0;
            retire_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            retire_q <= retire_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rs1_rd_en   = enable && (state_q == READ);
        rs2_rd_en   = enable && (state_q == READ);
        add_en      = enable && (state_q == EXEC) && (op == OP_ADD);
        sub_en      = enable && (state_q == EXEC) && (op == OP_SUB);
        bitrev_en   = enable && (state_q == EXEC) && (op == OP_BITREV);
        mul_en      = enable && (state_q == EXEC) && (op == OP_MUL);
        rd_wr_en    = enable && (state_q == WRITE);
        instr_done  = enable && (state_q == WRITE);
        busy        = (state_q != IDLE) || !empty;
        instr_ready = !full;
        rs1         = instr_q[9:5];
        rs2         = instr_q[4:0];
        rd          = instr_q[14:10];
        retire_cnt  = retire_q;
        fifo_level  = level_q;
    end

endmodule
